// File: rtl/mem_arb.sv
//==============================================================================
// Module   : mem_arb
// Brief    : CPU/DMA memory-bus arbiter with ROM wait states and RAM/ROM chip
//            selects. Define MEM_ARB_ROM_WAIT_EN to enable ROM read wait states.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_arb #(
    parameter int ROM_WAIT = 1,
    parameter int DMA_MAX  = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] cpu_ab,
    input  logic        cpu_we_n,
    output logic        cpu_rdy,
    input  logic        dma_req,
    input  logic [15:0] dma_ab,
    input  logic        dma_we_n,
    output logic        dma_gnt,
    output logic        dma_ack,
    output logic [15:0] AB,
    output logic        WE,
    output logic        RAM,
    output logic        ROM
);

    localparam logic       c_OWN_CPU  = 1'b0;
    localparam logic       c_OWN_DMA  = 1'b1;
    localparam logic [2:0] c_DMA_MAX  = 3'(DMA_MAX);
    localparam logic [15:0] c_ROM_BASE = 16'hD000;

    logic        r_owner;
    logic [2:0]  r_bcnt;
    logic [15:0] w_ab;
    logic        w_we_n;
    logic        w_rom_rd;
    logic        w_done;
    logic        w_grant_dma;

    always_comb begin
        w_ab   = cpu_ab;
        w_we_n = cpu_we_n;
        if (r_owner == c_OWN_DMA) begin
            w_ab   = dma_ab;
            w_we_n = dma_we_n;
        end
    end

    assign w_rom_rd = w_we_n && (w_ab >= c_ROM_BASE);

`ifdef MEM_ARB_ROM_WAIT_EN
    localparam logic [1:0] c_ROM_WAIT = 2'(ROM_WAIT);
    logic [1:0] r_wcnt;
    assign w_done = !w_rom_rd || (r_wcnt == c_ROM_WAIT);
`else
    assign w_done = 1'b1;
`endif

    // CPU always yields to a pending DMA; DMA keeps the bus until its burst is used up.
    assign w_grant_dma = dma_req && ((r_owner == c_OWN_CPU) || (r_bcnt < c_DMA_MAX));

    assign cpu_rdy = reset_n && w_done && (r_owner == c_OWN_CPU);
    assign dma_ack = reset_n && w_done && (r_owner == c_OWN_DMA);
    assign dma_gnt = reset_n && (r_owner == c_OWN_DMA);
    assign AB      = w_ab;
    assign WE      = !reset_n || w_we_n;
    assign RAM     = !reset_n || w_rom_rd;
    assign ROM     = !reset_n || !w_rom_rd;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_owner <= c_OWN_CPU;
            r_bcnt  <= 3'd0;
`ifdef MEM_ARB_ROM_WAIT_EN
            r_wcnt  <= 2'd0;
`endif
        end else if (w_done) begin
`ifdef MEM_ARB_ROM_WAIT_EN
            r_wcnt <= 2'd0;
`endif
            if (w_grant_dma) begin
                r_owner <= c_OWN_DMA;
                r_bcnt  <= (r_owner == c_OWN_CPU) ? 3'd1 : r_bcnt + 3'd1;
            end else begin
                r_owner <= c_OWN_CPU;
                r_bcnt  <= 3'd0;
            end
        end
`ifdef MEM_ARB_ROM_WAIT_EN
        else begin
            r_wcnt <= r_wcnt + 2'd1;
        end
`endif
    end

endmodule

`default_nettype wire

// File: doc/mem_arb.md
# mem_arb

Memory-bus controller for the CPLD 6502 board. It arbitrates the external 16-bit address bus between the CPU core and a secondary DMA requester (loader/video). It inserts wait states on Flash (ROM) reads and drives the active-low RAM/ROM chip selects and the CPU ready line. It sits between the core's address outputs and the board's memory pins.

## Interface
Parameters:
- ROM_WAIT, 1: extra cycles per ROM read, range 0..3.
- DMA_MAX, 4: maximum consecutive DMA accesses before the CPU is given one slot, range 1..7.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset_n  in  1  reset, synchronous, active-low.
- cpu_ab  in  16  CPU address.
- cpu_we_n  in  1  CPU write strobe, active-low.
- cpu_rdy  out  1  CPU access completes this cycle.
- dma_req  in  1  DMA requests the bus.
- dma_ab  in  16  DMA address.
- dma_we_n  in  1  DMA write strobe, active-low.
- dma_gnt  out  1  DMA owns the bus this cycle.
- dma_ack  out  1  DMA access completes this cycle.
- AB  out  16  memory address bus.
- WE  out  1  memory write enable, active-low.
- RAM  out  1  RAM chip select, active-low.
- ROM  out  1  Flash chip select, active-low.

## Operation
- State: owner register (CPU/DMA), wait counter wcnt (2 bits), burst counter bcnt (3 bits).
- Bus mux: AB/WE come from cpu_ab/cpu_we_n when owner=CPU, and from dma_ab/dma_we_n when owner=DMA. dma_gnt = (owner==DMA).
- Decode on the muxed bus:
  - Writes (WE=0): RAM=0, ROM=1 everywhere.
  - Reads with AB >= 16'hD000: ROM=0, RAM=1.
  - All other reads: RAM=0, ROM=1.
- rom_rd = read && AB >= 16'hD000. An access completes when !rom_rd or wcnt==ROM_WAIT.
- On the completion cycle, cpu_rdy=1 if owner=CPU, otherwise dma_ack=1.
- wcnt: cleared on the completion cycle, incremented otherwise.
- Arbitration is decided only on a completion cycle and takes effect next cycle:
  - owner=CPU, dma_req=1: owner becomes DMA, bcnt=1.
  - owner=DMA, dma_req=1 and bcnt<DMA_MAX: stay DMA, bcnt+1.
  - Otherwise: owner becomes CPU, bcnt=0.
- Non-completion cycles hold owner and bcnt unchanged. A request arriving mid-wait is never granted before the current access completes.
- Requesters hold address and strobe stable until rdy/ack. If the address changes mid-access, decode follows the new address and wcnt is not reset.

## Timing
- Reset (reset_n=0 at posedge): owner=CPU, wcnt=0, bcnt=0.
- While reset_n=0, outputs are gated: cpu_rdy=0, dma_ack=0, dma_gnt=0, RAM=1, ROM=1, WE=1. AB is don't-care.
- Reset asserted mid-access aborts it. No rdy/ack is issued for the aborted access.
- Outputs are combinational from registered state plus the requester inputs. There are no registered output delays.
- Latency:
  - RAM access or any write: 1 cycle.
  - ROM read: 1+ROM_WAIT cycles.
  - DMA request seen on a CPU completion cycle: granted on the next cycle.
- Bandwidth: with dma_req held high, steady state is DMA_MAX DMA accesses then 1 CPU access, repeating.
- The CPU is never starved. The DMA waits at most one CPU access after raising dma_req.

## Configuration
- MEM_ARB_ROM_WAIT_EN defined: ROM reads take 1+ROM_WAIT cycles as above.
- Not defined: wcnt is removed, ROM_WAIT is ignored, and every access completes in 1 cycle. Chip-select decode is unchanged.

## Test plan
- Reset: hold reset_n=0 for 2 cycles with dma_req=1 and cpu_ab=16'hE000 -> cpu_rdy=0, dma_ack=0, RAM=ROM=WE=1. On the first cycle after release, owner=CPU.
- CPU decode, ROM_WAIT=1:
  - Read 16'h1234 -> RAM=0, cpu_rdy=1 in cycle 0.
  - Read 16'hE000 -> ROM=0, cpu_rdy=0 in cycle 0 and 1 in cycle 1.
  - Write 16'hE000 -> RAM=0, ROM=1, WE=0, cpu_rdy=1 in cycle 0.
- Burst fairness: DMA_MAX=4, dma_req held high, both requesters on RAM -> owner sequence CPU,D,D,D,D,CPU,D,D,D,D. dma_ack is high in 8 of 10 cycles.
- Mid-wait request: CPU reads 16'hF000 with ROM_WAIT=2, and dma_req rises in wait cycle 1 -> cpu_rdy in cycle 2, dma_gnt first high in cycle 3.
- Reset mid-access: DMA reads 16'hF000, reset_n=0 in its wait cycle -> no dma_ack. The next cycle has owner=CPU, wcnt=0, bcnt=0.
- Macro off: CPU reads 16'hF000 -> ROM=0, cpu_rdy=1 in cycle 0.
